// File: rtl/ariane_axi.sv
// ariane_axi
//   Channel types for the core's AXI4 port. The initiator drives req_t
//   (AW/W/AR payloads and valids, plus B/R readies). The subordinate drives
//   resp_t (AW/W/AR readies, plus B/R payloads and valids).
//   Widths: 4-bit id, 64-bit address, 64-bit data, 8-bit strobe, 1-bit user.
package ariane_axi;

   localparam int IdWidth   = 4;
   localparam int AddrWidth = 64;
   localparam int DataWidth = 64;
   localparam int StrbWidth = DataWidth / 8;
   localparam int UserWidth = 1;

   typedef logic [IdWidth-1:0]   id_t;
   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [DataWidth-1:0] data_t;
   typedef logic [StrbWidth-1:0] strb_t;
   typedef logic [UserWidth-1:0] user_t;

   typedef struct packed {
      id_t         id;
      addr_t       addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  atop;
      user_t       user;
   } aw_chan_t;

   typedef struct packed {
      data_t data;
      strb_t strb;
      logic  last;
      user_t user;
   } w_chan_t;

   typedef struct packed {
      id_t        id;
      logic [1:0] resp;
      user_t      user;
   } b_chan_t;

   typedef struct packed {
      id_t         id;
      addr_t       addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      user_t       user;
   } ar_chan_t;

   typedef struct packed {
      id_t        id;
      data_t      data;
      logic [1:0] resp;
      logic       last;
      user_t      user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;

endpackage

// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg
//   Shared definitions for axi_mem_responder: FSM state encoding, AXI
//   response and burst codes, response-priority merge and the address
//   index / range-check helpers used per beat.
package axi_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_WAIT = 3'd1,
      ST_RD_BEAT = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_WR_RESP = 3'd4
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // Severity order DECERR > SLVERR > OKAY.
   function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
      if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
      if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

   function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
      return (addr - base) >> 3;
   endfunction

   // The lower-bound test comes first so an address below base never
   // reaches the subtraction as a huge wrapped index that looks valid.
   function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] base,
                                          input int unsigned num_words);
      return (addr >= base) && (word_index(addr, base) < 64'(num_words));
   endfunction

endpackage

// File: rtl/axi_mem_sram.sv
// axi_mem_sram
//   Single-port synchronous RAM, NumWords x 64 bits, per-byte write enables.
//   A read (en=1, we=0) presents the word on rdata one cycle later; rdata
//   holds its value until the next read, so a stalled beat stays stable.
//   No reset: contents survive rst.
// Ports
//   clk    in   1        clock
//   en     in   1        access enable
//   we     in   1        1 = write, 0 = read (qualified by en)
//   be     in   8        byte enables for writes
//   addr   in   IdxW     word index
//   wdata  in   64       write data
//   rdata  out  64       registered read data
module axi_mem_sram #(
   parameter int unsigned NumWords = 1024,
   parameter int unsigned IdxW     = $clog2(NumWords)
) (
   input  logic            clk,
   input  logic            en,
   input  logic            we,
   input  logic [7:0]      be,
   input  logic [IdxW-1:0] addr,
   input  logic [63:0]     wdata,
   output logic [63:0]     rdata
);

   logic [63:0] mem [NumWords];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 8; i++) begin
               if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 subordinate backed by an on-chip word array. One transaction at a
//   time; concurrent AR/AW requests are granted round-robin.
// Ports
//   clk_i       in   1                   clock
//   rst_i       in   1                   asynchronous active-high reset
//   axi_req_i   in   ariane_axi::req_t   AW/W/AR channels, B/R ready
//   axi_resp_o  out  ariane_axi::resp_t  AW/W/AR ready, B/R channels
//   busy_o      out  1                   high whenever the FSM is not IDLE
//
// Handshake: every channel transfers on a rising edge where valid and ready
// are both high. This block never withdraws r_valid/b_valid, nor changes the
// R/B payload, until the matching ready is seen.
module axi_mem_responder
   import axi_mem_pkg::*;
#(
   parameter int unsigned NumWords    = 1024,
   parameter logic [63:0] BaseAddr    = 64'h8000_0000,
   parameter int unsigned RespLatency = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  ariane_axi::req_t  axi_req_i,
   output ariane_axi::resp_t axi_resp_o,
   output logic              busy_o
);

   localparam int unsigned IdxW = $clog2(NumWords);

   state_e      state_q, state_d;
   logic [3:0]  id_q;
   logic [63:0] addr_q;
   logic [7:0]  len_q;
   logic [2:0]  size_q;
   logic [1:0]  burst_q;
   logic        txn_err_q;     // WRAP burst or atomic: SLVERR on every beat
   logic [7:0]  beat_q;
   logic [31:0] wait_q;
   logic        first_q;       // next RD_WAIT is the first one (pays RespLatency)
   logic [1:0]  b_resp_q;
   logic        prefer_rd_q;   // round-robin pointer: 1 = read wins a tie

   logic            grant_r, grant_w, ar_accept, aw_accept;
   logic            beat_ok, lat_done, rd_fetch, rd_last;
   logic            r_fire, w_fire, b_fire;
   logic [1:0]      beat_resp;
   logic [63:0]     next_addr, word_idx;
   logic            sram_en, sram_we;
   logic [63:0]     sram_rdata;

   assign grant_r   = axi_req_i.ar_valid & (~axi_req_i.aw_valid | prefer_rd_q);
   assign grant_w   = axi_req_i.aw_valid & ~grant_r;
   assign ar_accept = (state_q == ST_IDLE) & ~rst_i & grant_r;
   assign aw_accept = (state_q == ST_IDLE) & ~rst_i & grant_w;

   assign beat_ok   = addr_in_range(addr_q, BaseAddr, NumWords);
   assign beat_resp = worst_resp(beat_ok ? RESP_OKAY : RESP_DECERR,
                                 txn_err_q ? RESP_SLVERR : RESP_OKAY);
   assign next_addr = (burst_q == BURST_FIXED) ? addr_q : addr_q + (64'd1 << size_q);
   assign word_idx  = word_index(addr_q, BaseAddr);

   assign lat_done  = (wait_q >= RespLatency);
   // Only the first RD_WAIT of a burst pays the extra latency; later ones
   // are the single fetch bubble between beats.
   assign rd_fetch  = (state_q == ST_RD_WAIT) & (~first_q | lat_done);
   assign rd_last   = (beat_q == len_q);
   assign r_fire    = (state_q == ST_RD_BEAT) & axi_req_i.r_ready;
   assign w_fire    = (state_q == ST_WR_DATA) & axi_req_i.w_valid;
   assign b_fire    = (state_q == ST_WR_RESP) & lat_done & axi_req_i.b_ready;

   assign sram_we   = (state_q == ST_WR_DATA);
   assign sram_en   = rd_fetch | (w_fire & (beat_resp == RESP_OKAY));

   axi_mem_sram #(
      .NumWords (NumWords),
      .IdxW     (IdxW)
   ) u_sram (
      .clk   (clk_i),
      .en    (sram_en),
      .we    (sram_we),
      .be    (axi_req_i.w.strb),
      .addr  (word_idx[IdxW-1:0]),
      .wdata (axi_req_i.w.data),
      .rdata (sram_rdata)
   );

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ar_accept)      state_d = ST_RD_WAIT;
            else if (aw_accept) state_d = ST_WR_DATA;
         end
         ST_RD_WAIT: if (rd_fetch) state_d = ST_RD_BEAT;
         ST_RD_BEAT: if (r_fire)   state_d = rd_last ? ST_IDLE : ST_RD_WAIT;
         ST_WR_DATA: if (w_fire && axi_req_i.w.last) state_d = ST_WR_RESP;
         ST_WR_RESP: if (b_fire)   state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Output logic: payloads are zero whenever the matching valid is low.
   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.ar_ready = ar_accept;
      axi_resp_o.aw_ready = aw_accept;
      unique case (state_q)
         ST_RD_BEAT: begin
            axi_resp_o.r_valid = 1'b1;
            axi_resp_o.r.id    = id_q;
            axi_resp_o.r.data  = (beat_resp == RESP_OKAY) ? sram_rdata : 64'd0;
            axi_resp_o.r.resp  = beat_resp;
            axi_resp_o.r.last  = rd_last;
         end
         ST_WR_DATA: axi_resp_o.w_ready = 1'b1;
         ST_WR_RESP: begin
            if (lat_done) begin
               axi_resp_o.b_valid = 1'b1;
               axi_resp_o.b.id    = id_q;
               axi_resp_o.b.resp  = b_resp_q;
            end
         end
         default: ;
      endcase
   end

   assign busy_o = (state_q != ST_IDLE);

   // Transaction latches, beat/latency counters and round-robin pointer
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         txn_err_q   <= 1'b0;
         beat_q      <= '0;
         wait_q      <= '0;
         first_q     <= 1'b0;
         b_resp_q    <= RESP_OKAY;
         prefer_rd_q <= 1'b1;
      end else begin
         if (ar_accept) begin
            id_q        <= axi_req_i.ar.id;
            addr_q      <= axi_req_i.ar.addr;
            len_q       <= axi_req_i.ar.len;
            size_q      <= axi_req_i.ar.size;
            burst_q     <= axi_req_i.ar.burst;
            txn_err_q   <= (axi_req_i.ar.burst == BURST_WRAP);
            beat_q      <= '0;
            wait_q      <= '0;
            first_q     <= 1'b1;
            prefer_rd_q <= 1'b0;
         end
         if (aw_accept) begin
            id_q        <= axi_req_i.aw.id;
            addr_q      <= axi_req_i.aw.addr;
            len_q       <= axi_req_i.aw.len;
            size_q      <= axi_req_i.aw.size;
            burst_q     <= axi_req_i.aw.burst;
            txn_err_q   <= (axi_req_i.aw.burst == BURST_WRAP) || (axi_req_i.aw.atop != 6'd0);
            beat_q      <= '0;
            wait_q      <= '0;
            b_resp_q    <= RESP_OKAY;
            prefer_rd_q <= 1'b1;
         end
         if ((state_q == ST_RD_WAIT) && first_q && !lat_done) wait_q <= wait_q + 32'd1;
         if ((state_q == ST_WR_RESP) && !lat_done)            wait_q <= wait_q + 32'd1;
         if (r_fire || w_fire) begin
            addr_q <= next_addr;
            // Saturate rather than wrap so a runaway W stream cannot alias beat 0.
            if (beat_q != 8'hFF) beat_q <= beat_q + 8'd1;
         end
         if (r_fire) first_q <= 1'b0;
         if (w_fire) begin
            b_resp_q <= worst_resp(b_resp_q, beat_resp);
            if (axi_req_i.w.last) wait_q <= '0;
         end
      end
   end

   // Sideband fields the memory has no use for.
   logic unused_fields;
   assign unused_fields = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                            axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.user,
                            axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                            axi_req_i.ar.qos, axi_req_i.ar.region, axi_req_i.ar.user,
                            axi_req_i.w.user, word_idx[63:IdxW]};

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder
//   Directed bench for axi_mem_responder with hand-computed expectations.
module tb_axi_mem_responder;
   import ariane_axi::*;

   localparam int unsigned LAT    = 1;
   localparam int unsigned NWORDS = 1024;
   localparam int          BUDGET = 200;
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;
   localparam logic [1:0]  DECERR = 2'b11;
   localparam logic [1:0]  FIXED  = 2'b00;
   localparam logic [1:0]  INCR   = 2'b01;
   localparam logic [1:0]  WRAP   = 2'b10;

   // ---------------- clock / reset ----------------
   logic  clk = 1'b0;
   logic  rst;
   req_t  axi_req;
   resp_t axi_resp;
   logic  busy;
   int    cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axi_mem_responder #(
      .NumWords    (NWORDS),
      .BaseAddr    (64'h8000_0000),
      .RespLatency (LAT)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .axi_req_i  (axi_req),
      .axi_resp_o (axi_resp),
      .busy_o     (busy)
   );

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int ar_hs_cyc, first_r_cyc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic sb_check(input string tag, input logic [63:0] got);
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
      else check(tag, got, exp_q.pop_front());
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] burst);
      int n = 0;
      axi_req.ar       = '0;
      axi_req.ar.id    = id;
      axi_req.ar.addr  = addr;
      axi_req.ar.len   = len;
      axi_req.ar.size  = 3'd3;
      axi_req.ar.burst = burst;
      axi_req.ar_valid = 1'b1;
      #1;
      while (!axi_resp.ar_ready && n < BUDGET) begin @(posedge clk); #1; n++; end
      if (!axi_resp.ar_ready) check("ar_timeout", 64'(axi_resp.ar_ready), 64'd1);
      ar_hs_cyc = cyc;
      @(posedge clk); #1;
      axi_req.ar_valid = 1'b0;
   endtask

   task automatic do_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [5:0] atop);
      int n = 0;
      axi_req.aw       = '0;
      axi_req.aw.id    = id;
      axi_req.aw.addr  = addr;
      axi_req.aw.len   = len;
      axi_req.aw.size  = 3'd3;
      axi_req.aw.burst = burst;
      axi_req.aw.atop  = atop;
      axi_req.aw_valid = 1'b1;
      #1;
      while (!axi_resp.aw_ready && n < BUDGET) begin @(posedge clk); #1; n++; end
      if (!axi_resp.aw_ready) check("aw_timeout", 64'(axi_resp.aw_ready), 64'd1);
      @(posedge clk); #1;
      axi_req.aw_valid = 1'b0;
   endtask

   task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n = 0;
      axi_req.w.data  = data;
      axi_req.w.strb  = strb;
      axi_req.w.last  = last;
      axi_req.w_valid = 1'b1;
      #1;
      while (!axi_resp.w_ready && n < BUDGET) begin @(posedge clk); #1; n++; end
      if (!axi_resp.w_ready) check("w_timeout", 64'(axi_resp.w_ready), 64'd1);
      @(posedge clk); #1;
      axi_req.w_valid = 1'b0;
   endtask

   task automatic get_b(output logic [3:0] id, output logic [1:0] resp);
      int n = 0;
      axi_req.b_ready = 1'b1;
      #1;
      while (!axi_resp.b_valid && n < BUDGET) begin @(posedge clk); #1; n++; end
      if (!axi_resp.b_valid) check("b_timeout", 64'(axi_resp.b_valid), 64'd1);
      id   = axi_resp.b.id;
      resp = axi_resp.b.resp;
      @(posedge clk); #1;
      axi_req.b_ready = 1'b0;
   endtask

   task automatic wait_r();
      int n = 0;
      while (!axi_resp.r_valid && n < BUDGET) begin @(posedge clk); #1; n++; end
      if (!axi_resp.r_valid) check("r_timeout", 64'(axi_resp.r_valid), 64'd1);
   endtask

   task automatic get_r(output logic [63:0] data, output logic [1:0] resp, output logic last,
                        output logic [3:0] id);
      axi_req.r_ready = 1'b1;
      #1;
      wait_r();
      first_r_cyc = cyc;
      data = axi_resp.r.data;
      resp = axi_resp.r.resp;
      last = axi_resp.r.last;
      id   = axi_resp.r.id;
      @(posedge clk); #1;
      axi_req.r_ready = 1'b0;
   endtask

   // Single-beat read checked against the scoreboard head.
   task automatic read_check(input string tag, input logic [3:0] id, input logic [63:0] addr,
                             input logic [1:0] exp_resp);
      logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] rid;
      do_ar(id, addr, 8'd0, INCR);
      get_r(d, rs, l, rid);
      sb_check({tag, "_data"}, d);
      check({tag, "_resp"}, 64'(rs), 64'(exp_resp));
      check({tag, "_last"}, 64'(l), 64'd1);
      check({tag, "_id"}, 64'(rid), 64'(id));
   endtask

   task automatic write_check(input string tag, input logic [3:0] id, input logic [63:0] addr,
                              input logic [63:0] data, input logic [7:0] strb,
                              input logic [1:0] burst, input logic [5:0] atop,
                              input logic [1:0] exp_resp);
      logic [3:0] bid; logic [1:0] br;
      do_aw(id, addr, 8'd0, burst, atop);
      do_w(data, strb, 1'b1);
      get_b(bid, br);
      check({tag, "_bresp"}, 64'(br), 64'(exp_resp));
      check({tag, "_bid"}, 64'(bid), 64'(id));
   endtask

   // Present AR and AW together; serve whichever is granted first, then the other.
   task automatic dual(input logic [3:0] rid, input logic [63:0] raddr, input logic [63:0] rdata,
                       input logic [3:0] wid, input logic [63:0] waddr, input logic [63:0] wdata,
                       output logic rd_first);
      int n = 0;
      logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id_o; logic [1:0] br;
      axi_req.ar = '0; axi_req.ar.id = rid; axi_req.ar.addr = raddr;
      axi_req.ar.size = 3'd3; axi_req.ar.burst = INCR;
      axi_req.aw = '0; axi_req.aw.id = wid; axi_req.aw.addr = waddr;
      axi_req.aw.size = 3'd3; axi_req.aw.burst = INCR;
      axi_req.ar_valid = 1'b1;
      axi_req.aw_valid = 1'b1;
      #1;
      while (!axi_resp.ar_ready && !axi_resp.aw_ready && n < BUDGET) begin @(posedge clk); #1; n++; end
      if (!axi_resp.ar_ready && !axi_resp.aw_ready) check("dual_timeout", 64'(axi_resp.ar_ready), 64'd1);
      check("dual_one_ready", 64'(axi_resp.ar_ready & axi_resp.aw_ready), 64'd0);
      rd_first = axi_resp.ar_ready;
      @(posedge clk); #1;
      exp_q.push_back(rdata);
      if (rd_first) begin
         axi_req.ar_valid = 1'b0;
         get_r(d, rs, l, id_o);
         sb_check("dual_rdata", d);
         do_aw(wid, waddr, 8'd0, INCR, 6'd0);
         do_w(wdata, 8'hFF, 1'b1);
         get_b(id_o, br);
      end else begin
         axi_req.aw_valid = 1'b0;
         do_w(wdata, 8'hFF, 1'b1);
         get_b(id_o, br);
         do_ar(rid, raddr, 8'd0, INCR);
         get_r(d, rs, l, id_o);
         sb_check("dual_rdata", d);
      end
      check("dual_bresp", 64'(br), 64'(OKAY));
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      axi_req = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // ---------------- directed tests ----------------
   logic [63:0] wtab [4] = '{64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303,
                             64'h0404_0404_0404_0404, 64'h0505_0505_0505_0505};

   initial begin
      logic [63:0] d; logic [1:0] rs; logic l; logic [3:0] id_o; logic [1:0] br;
      logic rd_first;

      // Reset state, with AR/AW valid pending: nothing may be accepted.
      rst = 1'b1;
      axi_req = '0;
      axi_req.ar_valid = 1'b1;
      axi_req.aw_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ar_ready", 64'(axi_resp.ar_ready), 64'd0);
      check("rst_aw_ready", 64'(axi_resp.aw_ready), 64'd0);
      check("rst_valids", 64'({axi_resp.w_ready, axi_resp.b_valid, axi_resp.r_valid}), 64'd0);
      check("rst_r_payload", axi_resp.r.data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      axi_req = '0;
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: single write then read back, with first-beat latency.
      write_check("t1_wr", 4'd3, 64'h8000_0000, 64'hDEAD_BEEF_0123_4567, 8'hFF, INCR, 6'd0, OKAY);
      exp_q.push_back(64'hDEAD_BEEF_0123_4567);
      read_check("t1_rd", 4'd5, 64'h8000_0000, OKAY);
      check("t1_rd_latency", 64'(first_r_cyc - ar_hs_cyc), 64'(2 + LAT));

      // 2: burst write words 2..5, then burst read with r_ready toggling.
      do_aw(4'd1, 64'h8000_0010, 8'd3, INCR, 6'd0);
      for (int i = 0; i < 4; i++) do_w(wtab[i], 8'hFF, i == 3);
      get_b(id_o, br);
      check("t2_wr_bresp", 64'(br), 64'(OKAY));
      check("t2_wr_bid", 64'(id_o), 64'd1);
      for (int i = 0; i < 4; i++) exp_q.push_back(wtab[i]);
      do_ar(4'd7, 64'h8000_0010, 8'd3, INCR);
      for (int b = 0; b < 4; b++) begin
         axi_req.r_ready = 1'b0;
         wait_r();
         check("t2_beat_pre_stall", axi_resp.r.data, exp_q[0]);
         @(posedge clk); #1;
         check("t2_stall_valid", 64'(axi_resp.r_valid), 64'd1);
         check("t2_stall_id", 64'(axi_resp.r.id), 64'd7);
         check("t2_stall_last", 64'(axi_resp.r.last), 64'(b == 3));
         sb_check("t2_beat_data", axi_resp.r.data);
         axi_req.r_ready = 1'b1;
         @(posedge clk); #1;
         axi_req.r_ready = 1'b0;
      end
      check("t2_idle_after", 64'(busy), 64'd0);

      // 3: byte-strobed write over a zero word.
      write_check("t3_zero", 4'd2, 64'h8000_0050, 64'd0, 8'hFF, INCR, 6'd0, OKAY);
      write_check("t3_strb", 4'd2, 64'h8000_0050, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, INCR, 6'd0, OKAY);
      exp_q.push_back(64'h0000_0000_FFFF_FFFF);
      read_check("t3_rd", 4'd4, 64'h8000_0050, OKAY);

      // 4: decode errors, WRAP/atomic slave errors, burst crossing the top.
      exp_q.push_back(64'd0);
      read_check("t4_below", 4'd6, 64'h7FFF_FFF8, DECERR);
      exp_q.push_back(64'd0);
      read_check("t4_above", 4'd6, 64'h8000_2000, DECERR);
      write_check("t4_wrap", 4'd9, 64'h8000_0050, 64'h1234_5678_9ABC_DEF0, 8'hFF, WRAP, 6'd0, SLVERR);
      write_check("t4_atop", 4'd9, 64'h8000_0050, 64'h1234_5678_9ABC_DEF0, 8'hFF, INCR, 6'h21, SLVERR);
      exp_q.push_back(64'h0000_0000_FFFF_FFFF);
      read_check("t4_unchanged", 4'd4, 64'h8000_0050, OKAY);
      do_aw(4'd8, 64'h8000_1FF8, 8'd1, INCR, 6'd0);
      do_w(64'hA5A5_0000_0000_1023, 8'hFF, 1'b0);
      do_w(64'h5A5A_0000_0000_1024, 8'hFF, 1'b1);
      get_b(id_o, br);
      check("t4_cross_bresp", 64'(br), 64'(DECERR));
      do_ar(4'd8, 64'h8000_1FF8, 8'd1, INCR);
      get_r(d, rs, l, id_o);
      check("t4_cross_b0_data", d, 64'hA5A5_0000_0000_1023);
      check("t4_cross_b0_resp", 64'({rs, l}), 64'({OKAY, 1'b0}));
      get_r(d, rs, l, id_o);
      check("t4_cross_b1_data", d, 64'd0);
      check("t4_cross_b1_resp", 64'({rs, l}), 64'({DECERR, 1'b1}));

      // 5: round-robin after reset (pointer starts at read); array survives reset.
      apply_reset();
      exp_q.push_back(64'hDEAD_BEEF_0123_4567);
      read_check("t5_survive", 4'd1, 64'h8000_0000, OKAY);
      apply_reset();
      dual(4'd2, 64'h8000_0010, wtab[0], 4'd3, 64'h8000_0140, 64'h4040_0000_0000_0040, rd_first);
      check("t5_grant1_r", 64'(rd_first), 64'd1);
      dual(4'd2, 64'h8000_0018, wtab[1], 4'd3, 64'h8000_0148, 64'h4141_0000_0000_0041, rd_first);
      check("t5_grant3_r", 64'(rd_first), 64'd1);
      exp_q.push_back(wtab[2]);
      read_check("t5_lone_rd", 4'd5, 64'h8000_0020, OKAY);
      dual(4'd2, 64'h8000_0028, wtab[3], 4'd3, 64'h8000_0150, 64'h4242_0000_0000_0042, rd_first);
      check("t5_grant6_w", 64'(rd_first), 64'd0);
      write_check("t5_lone_wr", 4'd3, 64'h8000_0158, 64'h4343_0000_0000_0043, 8'hFF, INCR, 6'd0, OKAY);
      dual(4'd2, 64'h8000_0000, 64'hDEAD_BEEF_0123_4567, 4'd3, 64'h8000_0160,
           64'h4444_0000_0000_0044, rd_first);
      check("t5_grant9_r", 64'(rd_first), 64'd1);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({8'h40 + 8'(i), 8'h40 + 8'(i), 40'd0, 8'h40 + 8'(i)});
         read_check("t5_readback", 4'd0, 64'h8000_0140 + 64'(8 * i), OKAY);
      end

      // 6: reset during beat 2 of a len=7 read.
      do_ar(4'd6, 64'h8000_0010, 8'd7, INCR);
      get_r(d, rs, l, id_o);
      check("t6_b0", d, wtab[0]);
      get_r(d, rs, l, id_o);
      check("t6_b1", d, wtab[1]);
      wait_r();
      rst = 1'b1;
      #1;
      check("t6_rvalid_drop", 64'(axi_resp.r_valid), 64'd0);
      check("t6_busy_drop", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      axi_req.r_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("t6_no_more_beats", 64'(axi_resp.r_valid), 64'd0);
      axi_req.r_ready = 1'b0;
      exp_q.push_back(wtab[1]);
      read_check("t6_after", 4'd7, 64'h8000_0018, OKAY);

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
